// File: rtl/app_reg_bank_if.sv
// fx bus between the fabric (master) and one device register bank (slave).
// Byte-wide write/read strobes with a separate read-data valid return.
interface app_reg_bank_if;
  logic        fx_wr;
  logic [21:0] fx_waddr;
  logic [7:0]  fx_data;
  logic        fx_rd;
  logic [21:0] fx_raddr;
  logic [7:0]  fx_q;
  logic        fx_qv;

  modport master (
    output fx_wr, fx_waddr, fx_data, fx_rd, fx_raddr,
    input  fx_q, fx_qv
  );

  modport slave (
    input  fx_wr, fx_waddr, fx_data, fx_rd, fx_raddr,
    output fx_q, fx_qv
  );
endinterface

// File: rtl/app_reg_bank.sv
// Per-device fx-bus register bank: thresholds, sticky W1C status, irq mask, scratch, error count.
// Reads return RD_LAT cycles after the strobe, fully pipelined; no backpressure, every strobe is served.
module app_reg_bank #(
  parameter int          NUM_CH  = 4,
  parameter int          NUM_DBG = 8,
  parameter int          RD_LAT  = 1,
  parameter logic [15:0] TH_RST  = 16'h10,
  parameter logic [7:0]  VERSION = 8'h02
) (
  input  logic                clk_sys,
  input  logic                rst_n,
  input  logic [5:0]          dev_id,
  app_reg_bank_if.slave       fx,
  input  logic [NUM_CH-1:0]   stu_evt,
  output logic [16*NUM_CH-1:0] cfg_th,
  output logic                irq
);

  logic        wsel, rsel;
  logic [15:0] woff, roff;

  logic [15:0]       th [NUM_CH];
  logic [7:0]        shadow;
  logic [NUM_CH-1:0] sticky;
  logic [NUM_CH-1:0] mask;
  logic [NUM_CH-1:0] sticky_clr;
  logic [7:0]        dbg [NUM_DBG];
  logic [7:0]        err_cnt;
  logic [9:0]        err_sum;
  logic              werr, rerr, eclr;
  logic [7:0]        rdata;

  logic [7:0]        q_pipe [RD_LAT];
  logic [RD_LAT-1:0] v_pipe;

  assign wsel = fx.fx_wr && (fx.fx_waddr[21:16] == dev_id);
  assign rsel = fx.fx_rd && (fx.fx_raddr[21:16] == dev_id);
  assign woff = fx.fx_waddr[15:0];
  assign roff = fx.fx_raddr[15:0];

  function automatic logic is_mapped(input logic [15:0] off);
    logic m;
    m = (off == 16'h0000) || (off == 16'h0001) || (off == 16'h0010) ||
        (off == 16'h0011) || (off == 16'h00F0);
    for (int k = 0; k < 2*NUM_CH; k++)
      if (off == 16'(16'h40 + k)) m = 1'b1;
    for (int i = 0; i < NUM_DBG; i++)
      if (off == 16'(16'h80 + i)) m = 1'b1;
    return m;
  endfunction

  // Low byte only parks in the shared shadow; the high-byte write commits both halves at once.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      shadow <= 8'h00;
      for (int k = 0; k < NUM_CH; k++) th[k] <= TH_RST;
    end else if (wsel) begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (woff == 16'(16'h40 + 2*k)) shadow <= fx.fx_data;
        if (woff == 16'(16'h41 + 2*k)) th[k] <= {fx.fx_data, shadow};
      end
    end
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_th
    assign cfg_th[16*g +: 16] = th[g];
  end

  assign sticky_clr = (wsel && woff == 16'h0010) ? fx.fx_data[NUM_CH-1:0] : '0;

  // Event OR-ed in after the clear so a coincident event survives the W1C.
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      sticky <= '0;
      mask   <= '0;
      irq    <= 1'b0;
    end else begin
      sticky <= (sticky & ~sticky_clr) | stu_evt;
      if (wsel && woff == 16'h0011) mask <= fx.fx_data[NUM_CH-1:0];
      irq <= |(sticky & mask);
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_DBG; i++) dbg[i] <= 8'(8'h80 + i);
    end else if (wsel) begin
      for (int i = 0; i < NUM_DBG; i++)
        if (woff == 16'(16'h80 + i)) dbg[i] <= fx.fx_data;
    end
  end

  assign werr    = wsel && !is_mapped(woff);
  assign rerr    = rsel && !is_mapped(roff);
  assign eclr    = wsel && (woff == 16'h00F0);
  assign err_sum = {2'b00, err_cnt} + {9'd0, werr} + {9'd0, rerr};

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n)             err_cnt <= 8'h00;
    else if (eclr)          err_cnt <= 8'h00;
    else if (err_sum > 255) err_cnt <= 8'hFF;
    else                    err_cnt <= err_sum[7:0];
  end

  // Read mux sees pre-edge state, so a same-cycle write is not visible to the read.
  always_comb begin
    rdata = 8'h00;
    case (roff)
      16'h0000: rdata = {2'b00, dev_id};
      16'h0001: rdata = VERSION;
      16'h0010: rdata = 8'(sticky);
      16'h0011: rdata = 8'(mask);
      16'h00F0: rdata = err_cnt;
      default:  rdata = 8'h00;
    endcase
    for (int k = 0; k < NUM_CH; k++) begin
      if (roff == 16'(16'h40 + 2*k)) rdata = th[k][7:0];
      if (roff == 16'(16'h41 + 2*k)) rdata = th[k][15:8];
    end
    for (int i = 0; i < NUM_DBG; i++)
      if (roff == 16'(16'h80 + i)) rdata = dbg[i];
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      v_pipe <= '0;
      for (int s = 0; s < RD_LAT; s++) q_pipe[s] <= 8'h00;
    end else begin
      v_pipe[0] <= rsel;
      q_pipe[0] <= rsel ? rdata : 8'h00;
      for (int s = 1; s < RD_LAT; s++) begin
        v_pipe[s] <= v_pipe[s-1];
        q_pipe[s] <= q_pipe[s-1];
      end
    end
  end

  assign fx.fx_q  = q_pipe[RD_LAT-1];
  assign fx.fx_qv = v_pipe[RD_LAT-1];

endmodule

// File: tb/tb_app_reg_bank.sv
// Directed bench for app_reg_bank: two instances (RD_LAT=1 and RD_LAT=2), read data checked by queue-based monitors.
module tb_app_reg_bank;

  logic                  clk_sys = 1'b0;
  logic                  rst_n   = 1'b0;
  logic [5:0]            dev_id  = 6'd5;
  logic [3:0]            evt1    = '0;
  logic [3:0]            evt2    = '0;
  logic [63:0]           cfg_th1, cfg_th2;
  logic                  irq1, irq2;

  app_reg_bank_if fx1();
  app_reg_bank_if fx2();

  app_reg_bank #(.RD_LAT(1)) dut1 (
    .clk_sys(clk_sys), .rst_n(rst_n), .dev_id(dev_id), .fx(fx1),
    .stu_evt(evt1), .cfg_th(cfg_th1), .irq(irq1)
  );

  app_reg_bank #(.RD_LAT(2)) dut2 (
    .clk_sys(clk_sys), .rst_n(rst_n), .dev_id(dev_id), .fx(fx2),
    .stu_evt(evt2), .cfg_th(cfg_th2), .irq(irq2)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct {
    logic [7:0] dat;
    int         due;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int   edges  = 0;
  int   n_chk  = 0;
  int   n_fail = 0;

  always @(posedge clk_sys) edges <= edges + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_sys) begin
    exp_t e;
    if (fx1.fx_qv) begin
      if (q1.size() == 0) chk("rd1_unexpected_qv", fx1.fx_qv, 0);
      else begin
        e = q1.pop_front();
        chk("rd1_data", fx1.fx_q, e.dat);
        chk("rd1_latency", edges, e.due);
      end
    end else if (fx1.fx_q !== 8'h00) chk("rd1_idle_q", fx1.fx_q, 0);
  end

  always @(negedge clk_sys) begin
    exp_t e;
    if (fx2.fx_qv) begin
      if (q2.size() == 0) chk("rd2_unexpected_qv", fx2.fx_qv, 0);
      else begin
        e = q2.pop_front();
        chk("rd2_data", fx2.fx_q, e.dat);
        chk("rd2_latency", edges, e.due);
      end
    end else if (fx2.fx_q !== 8'h00) chk("rd2_idle_q", fx2.fx_q, 0);
  end

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic idle1();
    fx1.fx_wr = 1'b0; fx1.fx_rd = 1'b0;
  endtask

  task automatic wr(input logic [5:0] id, input logic [15:0] off, input logic [7:0] d);
    fx1.fx_wr = 1'b1; fx1.fx_waddr = {id, off}; fx1.fx_data = d;
    tick();
    fx1.fx_wr = 1'b0;
  endtask

  task automatic rd(input logic [15:0] off, input logic [7:0] exp);
    fx1.fx_rd = 1'b1; fx1.fx_raddr = {dev_id, off};
    q1.push_back('{dat: exp, due: edges + 1});
    tick();
    fx1.fx_rd = 1'b0;
  endtask

  task automatic rd_foreign(input logic [5:0] id, input logic [15:0] off);
    fx1.fx_rd = 1'b1; fx1.fx_raddr = {id, off};
    tick();
    fx1.fx_rd = 1'b0;
  endtask

  task automatic wrrd(input logic [15:0] woff, input logic [7:0] d,
                      input logic [15:0] roff, input logic [7:0] exp);
    fx1.fx_wr = 1'b1; fx1.fx_waddr = {dev_id, woff}; fx1.fx_data = d;
    fx1.fx_rd = 1'b1; fx1.fx_raddr = {dev_id, roff};
    q1.push_back('{dat: exp, due: edges + 1});
    tick();
    idle1();
  endtask

  task automatic rd2(input logic [15:0] off, input logic [7:0] exp);
    fx2.fx_rd = 1'b1; fx2.fx_raddr = {dev_id, off};
    q2.push_back('{dat: exp, due: edges + 2});
    tick();
    fx2.fx_rd = 1'b0;
  endtask

  initial begin
    idle1();
    fx1.fx_waddr = '0; fx1.fx_data = '0; fx1.fx_raddr = '0;
    fx2.fx_wr = 1'b0; fx2.fx_rd = 1'b0;
    fx2.fx_waddr = '0; fx2.fx_data = '0; fx2.fx_raddr = '0;

    repeat (3) tick();
    chk("rst_cfg_th", cfg_th1, {4{16'h0010}});
    chk("rst_irq", irq1, 0);
    chk("rst_qv", fx1.fx_qv, 0);
    chk("rst_q", fx1.fx_q, 0);
    rst_n = 1'b1;
    tick();

    // Identity, version, reset thresholds/scratch, latency on both instances
    rd(16'h00, 8'h05); rd(16'h01, 8'h02); rd(16'h40, 8'h10); rd(16'h41, 8'h00);
    rd(16'h80, 8'h80); rd(16'h87, 8'h87);
    rd2(16'h00, 8'h05);
    repeat (3) tick();

    // Atomic threshold commit
    wr(dev_id, 16'h40, 8'h34);
    chk("th0_after_lo", cfg_th1[15:0], 16'h0010);
    rd(16'h40, 8'h10);
    wr(dev_id, 16'h41, 8'h12);
    chk("th0_after_hi", cfg_th1[15:0], 16'h1234);
    wr(dev_id, 16'h43, 8'h56);
    chk("th1_shadow_reuse", cfg_th1[31:16], 16'h5634);
    chk("th_others", cfg_th1[63:32], {2{16'h0010}});
    rd(16'h42, 8'h34); rd(16'h43, 8'h56);

    // Same-cycle write/read returns the old value
    wrrd(16'h81, 8'h11, 16'h81, 8'h81);
    rd(16'h81, 8'h11);

    // Sticky, mask, irq
    evt1 = 4'b0100; tick(); evt1 = '0;
    chk("irq_masked", irq1, 0);
    wr(dev_id, 16'h11, 8'h04);
    chk("irq_before_reg", irq1, 0);
    tick();
    chk("irq_set", irq1, 1);
    rd(16'h10, 8'h04);
    wr(dev_id, 16'h11, 8'hF4);
    rd(16'h11, 8'h04);
    evt1 = 4'b0100;
    wr(dev_id, 16'h10, 8'h04);
    evt1 = '0;
    tick();
    chk("irq_set_wins", irq1, 1);
    rd(16'h10, 8'h04);
    wr(dev_id, 16'h10, 8'h04);
    chk("irq_prev_cond", irq1, 1);
    tick();
    chk("irq_clear", irq1, 0);
    rd(16'h10, 8'h00);

    // Error counter
    rd(16'h33, 8'h00);
    wr(dev_id, 16'h90, 8'h77);
    rd(16'hF0, 8'h02);
    for (int i = 0; i < 300; i++) rd(16'h33, 8'h00);
    rd(16'hF0, 8'hFF);
    wr(dev_id, 16'hF0, 8'h00);
    rd(16'hF0, 8'h00);
    rd(16'h33, 8'h00);
    wrrd(16'hF0, 8'h00, 16'h33, 8'h00);
    rd(16'hF0, 8'h00);
    rd(16'h48, 8'h00); rd(16'h88, 8'h00);
    rd(16'hF0, 8'h02);

    // Foreign device ID is ignored entirely
    wr(6'd6, 16'h80, 8'hAA);
    rd(16'h80, 8'h80);
    rd_foreign(6'd6, 16'h33);
    rd_foreign(6'd6, 16'h80);
    repeat (3) tick();
    rd(16'hF0, 8'h02);
    repeat (3) tick();
    chk("q1_drained", q1.size(), 0);

    // RD_LAT=2: back-to-back reads, then reset with a read still on the output
    rd2(16'h00, 8'h05); rd2(16'h01, 8'h02); rd2(16'h80, 8'h80);
    repeat (4) tick();
    rd2(16'h40, 8'h10); rd2(16'h41, 8'h00);
    @(negedge clk_sys);
    tick();
    chk("rst_mid_pre_qv", fx2.fx_qv, 1);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_qv", fx2.fx_qv, 0);
    chk("rst_mid_q", fx2.fx_q, 0);
    q2.delete();
    repeat (2) tick();
    chk("rst_hold_qv", fx2.fx_qv, 0);
    rst_n = 1'b1;
    tick();
    chk("rst2_cfg_th", cfg_th1, {4{16'h0010}});
    chk("rst2_irq", irq1, 0);
    rd(16'h81, 8'h81);
    rd2(16'h40, 8'h10);
    repeat (4) tick();
    chk("q1_final", q1.size(), 0);
    chk("q2_final", q2.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
